store_commit_queue: RTL and testbench
=====================================

// Module: store_commit_queue
// PURPOSE
//  Downstream of the store reservation buffer. Accepts issued SW ops (instr no, base, offset, data).
//  Computes effective address, reports completion to the ROB, and holds each store until the ROB commits it.
//  Drains committed stores to the data cache in program order over a req/ack handshake.
//  Discards uncommitted stores on flush.
// PARAMETERS
//  DEPTH  8  queue entries (power of 2)
//  AW     3  log2(DEPTH); pointers are AW+1 bits (wrap bit)
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset: synchronous, active-high
//  st_valid         in   1   issued store present this cycle
//  st_ready         out  1   queue can accept (not full, no flush, not in rst)
//  st_instr_no      in   32  ROB instruction number
//  st_base          in   32  rs register value
//  st_offset        in   16  immediate offset (sign-extended internally)
//  st_data          in   32  rt register value (store data)
//  done_valid       out  1   completion report to ROB (1-cycle pulse)
//  done_instr_no    out  32  instr no of completed store
//  done_exc         out  1   1 = misaligned address exception
//  commit_valid     in   1   ROB commits a store this cycle
//  commit_instr_no  in   32  instr no being committed
//  commit_err       out  1   pulse: commit did not match next-to-commit entry
//  flush            in   1   discard all uncommitted entries
//  ld_chk_addr      in   32  load address to check for RAW hazard
//  ld_conflict      out  1   combinational: any valid entry matches ld_chk_addr[31:2]
//  dc_wr_req        out  1   data-cache write request
//  dc_addr          out  32  write address (word aligned)
//  dc_wdata         out  32  write data
//  dc_ack           in   1   cache accepted write
// BEHAVIOUR
//  Pointers: head (drain), cptr (next to commit), tail (alloc).
//   Committed region = [head,cptr); uncommitted region = [cptr,tail).
//   count = tail-head; full when count==DEPTH; wrap via MSB compare.
//  Reset: pointers=0, all entries invalid, FSM=IDLE.
//   done_valid, done_exc, commit_err, dc_wr_req = 0; dc_addr, dc_wdata, done_instr_no = 0.
//   st_ready=0 while rst high, 1 the cycle after. Reset mid-drain drops dc_wr_req at that edge.
//  Accept: st_valid & st_ready at posedge -> write entry[tail], tail+=1.
//   EA = st_base + {{16{off[15]}},off} (32-bit wrap, no overflow flag); exc = |EA[1:0].
//  Completion: accept at edge N -> done_valid=1 after edge N+1 (one cycle), carrying instr_no and exc.
//  Commit: commit_valid & entry[cptr] valid & instr_no match -> cptr+=1.
//   If cptr==tail or mismatch: commit_err=1 for one cycle, no state change.
//   Committing an exc entry: entry popped at drain without any cache write.
//  Flush: tail<=cptr; done_valid suppressed that cycle.
//   Same-cycle commit+flush: commit applied first, then flush (committed entry survives).
//   Same-cycle accept+flush: st_ready=0, so no accept.
//  Drain FSM:
//   IDLE: head!=cptr -> if entry exc: head+=1, stay IDLE; else load dc_addr/dc_wdata, go REQ.
//   REQ: dc_wr_req=1; addr/data held stable until dc_ack.
//        dc_ack -> head+=1, dc_wr_req=0, go IDLE.
//   Max 1 write per 2 cycles. Flush never affects REQ (head entry is committed).
//  ld_conflict: compares EA[31:2] of all entries in [head,tail), including the one in REQ.
//  Simultaneous accept + drain pop when full: pop does not free space for the same edge (st_ready already 0).
// TESTING
//  1. Reset, accept SW no=5 base=0x100 off=0xFFFC data=0xAA -> next cycle done_valid, instr_no=5, exc=0.
//     Commit 5 -> dc_wr_req, addr=0xFC, wdata=0xAA; ack -> queue empty.
//  2. Accept 8 stores with no commit -> st_ready=0 after 8th; 9th held.
//     Commit+drain one -> st_ready returns to 1.
//  3. base=0x101 off=0 -> done_exc=1; commit it -> head advances with no dc_wr_req.
//  4. Accept nos 1,2,3; commit 1; flush in same cycle as commit 2 -> 1,2 drain to cache, 3 never written, tail==cptr.
//  5. Commit no=9 when head uncommitted is no=7 -> commit_err pulse, cptr unchanged.
//     ld_chk_addr=EA(7)+2 -> ld_conflict=1.
//  6. Assert rst while dc_wr_req=1 with ack low -> next cycle dc_wr_req=0, count=0, st_ready=0 then 1.

Source files
------------

// File: rtl/store_commit_queue_if.sv
// Handshake and data bundle between the issue stage, ROB, load unit and data cache
// and the store commit queue.
interface store_commit_queue_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_instr_no;
  logic [31:0] st_base;
  logic [15:0] st_offset;
  logic [31:0] st_data;

  logic        done_valid;
  logic [31:0] done_instr_no;
  logic        done_exc;

  logic        commit_valid;
  logic [31:0] commit_instr_no;
  logic        commit_err;
  logic        flush;

  logic [31:0] ld_chk_addr;
  logic        ld_conflict;

  logic        dc_wr_req;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_ack;

  modport master (
    output st_valid, st_instr_no, st_base, st_offset, st_data,
    output commit_valid, commit_instr_no, flush, ld_chk_addr, dc_ack,
    input  st_ready, done_valid, done_instr_no, done_exc, commit_err,
    input  ld_conflict, dc_wr_req, dc_addr, dc_wdata
  );

  modport slave (
    input  st_valid, st_instr_no, st_base, st_offset, st_data,
    input  commit_valid, commit_instr_no, flush, ld_chk_addr, dc_ack,
    output st_ready, done_valid, done_instr_no, done_exc, commit_err,
    output ld_conflict, dc_wr_req, dc_addr, dc_wdata
  );
endinterface

// File: rtl/store_commit_queue.sv
// Store commit queue: computes store EA, reports completion, holds stores until ROB commit,
// then drains committed stores in order to the data cache over req/ack.
module store_commit_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  store_commit_queue_if.slave bus
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_DEPTH = {1'b1, {AW{1'b0}}};

  state_t            r_state, w_state_nxt;
  logic [AW:0]       r_head, r_cptr, r_tail;
  logic [31:0]       r_ea    [DEPTH];
  logic [31:0]       r_data  [DEPTH];
  logic [31:0]       r_instr [DEPTH];
  logic [DEPTH-1:0]  r_exc;

  logic              r_pend_vld, r_pend_exc;
  logic [31:0]       r_pend_instr;
  logic              r_done_vld, r_done_exc, r_commit_err;
  logic [31:0]       r_done_instr, r_dc_addr, r_dc_wdata;

  logic [AW:0]       w_count, w_cptr_nxt;
  logic [AW-1:0]     w_hidx, w_cidx, w_tidx;
  logic [31:0]       w_ea;
  logic              w_full, w_st_ready, w_acc;
  logic              w_cmt_ok, w_cmt_err;
  logic              w_pop, w_load, w_conf;
  logic              w_unused_ok;

  assign w_hidx  = r_head[AW-1:0];
  assign w_cidx  = r_cptr[AW-1:0];
  assign w_tidx  = r_tail[AW-1:0];
  assign w_count = r_tail - r_head;
  assign w_full  = (w_count == PTR_DEPTH);

  assign w_ea       = bus.st_base + {{16{bus.st_offset[15]}}, bus.st_offset};
  assign w_st_ready = !rst && !bus.flush && !w_full;
  assign w_acc      = bus.st_valid && w_st_ready;

  assign w_cmt_ok   = bus.commit_valid && (r_cptr != r_tail) &&
                      (r_instr[w_cidx] == bus.commit_instr_no);
  assign w_cmt_err  = bus.commit_valid && !w_cmt_ok;
  assign w_cptr_nxt = w_cmt_ok ? (r_cptr + PTR_ONE) : r_cptr;

  // Drain FSM: misaligned entries retire in IDLE without touching the cache.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_head != r_cptr) begin
          if (r_exc[w_hidx]) begin
            w_pop = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.dc_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_ea[w_tidx]    <= w_ea;
      r_data[w_tidx]  <= bus.st_data;
      r_instr[w_tidx] <= bus.st_instr_no;
      r_exc[w_tidx]   <= |w_ea[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_cptr       <= '0;
      r_tail       <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_exc   <= 1'b0;
      r_pend_instr <= '0;
      r_done_vld   <= 1'b0;
      r_done_exc   <= 1'b0;
      r_done_instr <= '0;
      r_commit_err <= 1'b0;
      r_dc_addr    <= '0;
      r_dc_wdata   <= '0;
    end else begin
      if (w_pop) r_head <= r_head + PTR_ONE;
      r_cptr <= w_cptr_nxt;
      // Flush trims the uncommitted region after this cycle's commit has landed.
      if (bus.flush)  r_tail <= w_cptr_nxt;
      else if (w_acc) r_tail <= r_tail + PTR_ONE;

      r_pend_vld   <= w_acc;
      r_pend_exc   <= |w_ea[1:0];
      r_pend_instr <= bus.st_instr_no;
      r_done_vld   <= r_pend_vld && !bus.flush;
      r_done_exc   <= r_pend_vld && !bus.flush && r_pend_exc;
      if (r_pend_vld) r_done_instr <= r_pend_instr;

      r_commit_err <= w_cmt_err;

      if (w_load) begin
        r_dc_addr  <= {r_ea[w_hidx][31:2], 2'b00};
        r_dc_wdata <= r_data[w_hidx];
      end
    end
  end

  // RAW check covers every live entry, including the one currently in REQ.
  always_comb begin
    w_conf = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, AW'(i) - w_hidx} < w_count) &&
          (r_ea[i][31:2] == bus.ld_chk_addr[31:2]))
        w_conf = 1'b1;
    end
  end

  assign w_unused_ok = &{1'b0, bus.ld_chk_addr[1:0]};

  assign bus.st_ready      = w_st_ready;
  assign bus.done_valid    = r_done_vld;
  assign bus.done_instr_no = r_done_instr;
  assign bus.done_exc      = r_done_exc;
  assign bus.commit_err    = r_commit_err;
  assign bus.ld_conflict   = w_conf;
  assign bus.dc_wr_req     = (r_state == S_REQ);
  assign bus.dc_addr       = r_dc_addr;
  assign bus.dc_wdata      = r_dc_wdata;

endmodule

// File: tb/tb_store_commit_queue.sv
// Scoreboard bench for store_commit_queue: completions and cache writes are predicted
// when stimulus is driven and compared as the DUT produces them.
module tb_store_commit_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_commit_queue_if bus ();

  store_commit_queue #(.DEPTH(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] no;
    logic [31:0] ea;
    logic [31:0] data;
    logic        exc;
  } st_t;

  st_t         unc_q[$];
  logic [32:0] done_q[$];
  logic [63:0] wr_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  bit auto_ack = 1'b1;
  bit seen_req = 1'b0;

  // Output monitor: completion reports and cache writes against the scoreboard.
  always @(negedge clk) begin
    logic [32:0] exp_done;
    logic [63:0] exp_wr;
    if (bus.done_valid) begin
      n_cmp++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got no=%0d exc=%0d, none expected", bus.done_instr_no, bus.done_exc);
      end else begin
        exp_done = done_q.pop_front();
        if ({bus.done_exc, bus.done_instr_no} !== exp_done) begin
          n_fail++;
          $display("FAIL done_report: got exc=%0d no=%0d, want exc=%0d no=%0d",
                   bus.done_exc, bus.done_instr_no, exp_done[32], exp_done[31:0]);
        end
      end
    end
    if (bus.dc_wr_req && !seen_req) begin
      seen_req = 1'b1;
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL dc_write_unexpected: got addr=%h data=%h", bus.dc_addr, bus.dc_wdata);
      end else begin
        exp_wr = wr_q.pop_front();
        if ({bus.dc_addr, bus.dc_wdata} !== exp_wr) begin
          n_fail++;
          $display("FAIL dc_write: got addr=%h data=%h, want addr=%h data=%h",
                   bus.dc_addr, bus.dc_wdata, exp_wr[63:32], exp_wr[31:0]);
        end
      end
    end
    if (!bus.dc_wr_req) seen_req = 1'b0;
    bus.dc_ack = bus.dc_wr_req && auto_ack;
  end

  task automatic clear_model();
    unc_q.delete();
    done_q.delete();
    wr_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.st_valid = 1'b0;
    bus.commit_valid = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_model();
    rst = 1'b0;
  endtask

  task automatic accept(input logic [31:0] no, input logic [31:0] base,
                        input logic [15:0] off, input logic [31:0] data);
    int  t = 0;
    st_t s;
    while (!bus.st_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.st_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: st_ready=%0d for no=%0d, want 1", bus.st_ready, no);
      return;
    end
    bus.st_valid = 1'b1;
    bus.st_instr_no = no;
    bus.st_base = base;
    bus.st_offset = off;
    bus.st_data = data;
    s.no = no;
    s.ea = base + {{16{off[15]}}, off};
    s.exc = |s.ea[1:0];
    s.data = data;
    @(posedge clk);
    unc_q.push_back(s);
    done_q.push_back({s.exc, no});
    @(negedge clk);
    bus.st_valid = 1'b0;
  endtask

  task automatic commit(input logic [31:0] no, input bit fl);
    bit  exp_err;
    st_t s;
    exp_err = (unc_q.size() == 0) || (unc_q[0].no != no);
    if (!exp_err) begin
      s = unc_q.pop_front();
      if (!s.exc) wr_q.push_back({s.ea, s.data});
    end
    if (fl) unc_q.delete();
    bus.commit_valid = 1'b1;
    bus.commit_instr_no = no;
    bus.flush = fl;
    @(posedge clk);
    @(negedge clk);
    bus.commit_valid = 1'b0;
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.commit_err !== exp_err) begin
      n_fail++;
      $display("FAIL commit_err no=%0d: got %0d, want %0d", no, bus.commit_err, exp_err);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0 || bus.dc_wr_req) && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (wr_q.size() != 0 || done_q.size() != 0 || bus.dc_wr_req) begin
      n_fail++;
      $display("FAIL drain_timeout: writes left=%0d dones left=%0d req=%0d, want 0/0/0",
               wr_q.size(), done_q.size(), bus.dc_wr_req);
    end
  endtask

  task automatic check_conflict(input logic [31:0] addr, input logic exp, input string tag);
    bus.ld_chk_addr = addr;
    #1;
    n_cmp++;
    if (bus.ld_conflict !== exp) begin
      n_fail++;
      $display("FAIL %s: ld_conflict=%0d at %h, want %0d", tag, bus.ld_conflict, addr, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.st_valid = 1'b0;
    bus.commit_valid = 1'b0;
    bus.flush = 1'b0;
    bus.ld_chk_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.st_ready, bus.done_valid, bus.done_exc, bus.commit_err, bus.dc_wr_req} !== 5'b0 ||
        bus.dc_addr !== 32'h0 || bus.dc_wdata !== 32'h0 || bus.done_instr_no !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0d dv=%0d de=%0d ce=%0d req=%0d addr=%h wd=%h dno=%h, want all 0",
               bus.st_ready, bus.done_valid, bus.done_exc, bus.commit_err, bus.dc_wr_req,
               bus.dc_addr, bus.dc_wdata, bus.done_instr_no);
    end
    @(negedge clk);
    clear_model();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %0d, want 1", bus.st_ready);
    end
  endtask

  task automatic test_basic();
    accept(5, 32'h100, 16'hFFFC, 32'hAA);
    @(negedge clk);
    n_cmp++;
    if (bus.done_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL done_latency: done_valid=%0d one cycle after accept, want 1", bus.done_valid);
    end
    commit(5, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.dc_wr_req !== 1'b1 || bus.dc_addr !== 32'hFC || bus.dc_wdata !== 32'hAA) begin
      n_fail++;
      $display("FAIL drain_first: req=%0d addr=%h wd=%h, want 1 000000fc 000000aa",
               bus.dc_wr_req, bus.dc_addr, bus.dc_wdata);
    end
    wait_idle();
    check_conflict(32'hFC, 1'b0, "basic_empty");
  endtask

  task automatic test_full();
    int  t = 0;
    bit  held_ok = 1'b1;
    for (int i = 0; i < 8; i++)
      accept(10 + i, 32'h1000 + 32'(4 * i), 16'h0, 32'h100 + 32'(i));
    n_cmp++;
    if (bus.st_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: st_ready=%0d after 8 accepts, want 0", bus.st_ready);
    end
    bus.st_valid = 1'b1;
    bus.st_instr_no = 18;
    bus.st_base = 32'h1020;
    bus.st_offset = 16'h0;
    bus.st_data = 32'h108;
    repeat (3) begin
      @(negedge clk);
      if (bus.st_ready !== 1'b0) held_ok = 1'b0;
    end
    bus.st_valid = 1'b0;
    n_cmp++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL full_hold: st_ready rose while full with no drain, want 0");
    end
    commit(10, 1'b0);
    while (!bus.st_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_release: st_ready=%0d after drain, want 1", bus.st_ready);
    end
    accept(18, 32'h1020, 16'h0, 32'h108);
    for (int i = 11; i <= 18; i++) commit(i, 1'b0);
    wait_idle();
  endtask

  task automatic test_exc();
    bit no_req = 1'b1;
    accept(20, 32'h101, 16'h0, 32'h55);
    wait_idle();
    check_conflict(32'h100, 1'b1, "exc_conflict_live");
    commit(20, 1'b0);
    repeat (3) begin
      @(negedge clk);
      if (bus.dc_wr_req !== 1'b0) no_req = 1'b0;
    end
    n_cmp++;
    if (!no_req) begin
      n_fail++;
      $display("FAIL exc_no_write: dc_wr_req seen for misaligned store, want 0");
    end
    check_conflict(32'h100, 1'b0, "exc_popped");
  endtask

  task automatic test_flush();
    accept(1, 32'h300, 16'h0, 32'h11);
    accept(2, 32'h304, 16'h0, 32'h22);
    accept(3, 32'h308, 16'h0, 32'h33);
    wait_idle();
    commit(1, 1'b0);
    commit(2, 1'b1);
    wait_idle();
    check_conflict(32'h308, 1'b0, "flush_discard");
    commit(3, 1'b0);
  endtask

  task automatic test_commit_err();
    accept(7, 32'h200, 16'h4, 32'h77);
    wait_idle();
    check_conflict(32'h206, 1'b1, "raw_hit");
    check_conflict(32'h20C, 1'b0, "raw_miss");
    commit(9, 1'b0);
    commit(7, 1'b0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      accept(40 + i, 32'h800 + 32'(8 * i), 16'hFFFC, 32'hC0 + 32'(i));
    for (int i = 0; i < 4; i++) commit(40 + i, 1'b0);
    wait_idle();
  endtask

  task automatic test_reset_mid_drain();
    int t = 0;
    auto_ack = 1'b0;
    accept(30, 32'h400, 16'h0, 32'h99);
    commit(30, 1'b0);
    while (!bus.dc_wr_req && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.dc_wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_drain_req: dc_wr_req=%0d, want 1", bus.dc_wr_req);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.dc_wr_req !== 1'b0 || bus.st_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drain: req=%0d rdy=%0d, want 0 0", bus.dc_wr_req, bus.st_ready);
    end
    check_conflict(32'h400, 1'b0, "rst_count_zero");
    @(negedge clk);
    clear_model();
    rst = 1'b0;
    auto_ack = 1'b1;
    #1;
    n_cmp++;
    if (bus.st_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready_back: st_ready=%0d, want 1", bus.st_ready);
    end
  endtask

  initial begin
    bus.st_valid = 1'b0;
    bus.st_instr_no = '0;
    bus.st_base = '0;
    bus.st_offset = '0;
    bus.st_data = '0;
    bus.commit_valid = 1'b0;
    bus.commit_instr_no = '0;
    bus.flush = 1'b0;
    bus.ld_chk_addr = '0;
    bus.dc_ack = 1'b0;
    test_reset();
    test_basic();
    do_reset();
    test_full();
    test_exc();
    test_flush();
    test_commit_err();
    test_back_to_back();
    test_reset_mid_drain();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_q.size() != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: dones=%0d writes=%0d outstanding, want 0 0", done_q.size(), wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
